jk_reg_array: RTL and testbench

Parametrised bank of WIDTH flip-flops with run-time selectable behaviour: JK, D, T or SR. It replaces discrete single-bit JK flip-flops wherever the design needs multi-bit state registers. Every bit is updated in parallel from per-bit J/K inputs under a common enable. The block also reports per-cycle change activity, flags illegal SR input combinations with a sticky bit, and can optionally count bit transitions.

---
 rtl/jk_reg_array.sv | 136 +++++++++++++
 tb/tb_jk_reg_array.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/jk_reg_array.sv
// jk_reg_array
// A parallel bank of WIDTH flip-flops. The mode input selects the behaviour of
// every bit for the current edge: JK, D, T or SR. The block also reports
// whether the last edge changed any bit, keeps a sticky flag for illegal SR
// inputs, and can optionally count bit transitions.
//
// Configuration:
//   JK_REG_TOGGLE_CNT_EN - when defined, the saturating transition counter is
//                          built. When undefined, toggle_cnt is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         update enable; 0 holds all state
//   mode       00 JK, 01 D, 10 T, 11 SR
//   j          per-bit J / D / T / S input
//   k          per-bit K / R input (ignored in D and T modes)
//   clr_err    synchronous clear of sr_err (a new set in the same cycle wins)
//   q          registered state
//   q_n        complement of q
//   changed    1 when the last edge altered at least one bit
//   sr_err     sticky flag for j=k=1 seen in SR mode
//   toggle_cnt saturating count of bit transitions
module jk_reg_array #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             changed,
  output logic             sr_err,
  output logic [CNT_W-1:0] toggle_cnt
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

  mode_t            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] sr_illegal;
  logic [WIDTH-1:0] diff;
  logic             sr_set;

  assign mode_sel   = mode_t'(mode);
  assign sr_illegal = j & k;

  // Per-bit next state. In SR mode a bit with S=R=1 keeps its value.
  always_comb begin
    q_next = q;
    case (mode_sel)
      MODE_JK: q_next = (j & ~q) | (~k & q);
      MODE_D:  q_next = j;
      MODE_T:  q_next = q ^ j;
      MODE_SR: q_next = (sr_illegal & q) | (~sr_illegal & (j | (q & ~k)));
      default: q_next = q;
    endcase
  end

  assign diff   = en ? (q_next ^ q) : '0;
  assign sr_set = en && (mode_sel == MODE_SR) && (|sr_illegal);

  // State register plus activity and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= RST_VAL;
      changed <= 1'b0;
      sr_err  <= 1'b0;
    end else begin
      if (en) begin
        q <= q_next;
      end
      changed <= |diff;
      if (sr_set) begin
        sr_err <= 1'b1;
      end else if (clr_err) begin
        sr_err <= 1'b0;
      end
    end
  end

  // q_n comes straight from the register, so it is never out of step with q.
  assign q_n = ~q;

`ifdef JK_REG_TOGGLE_CNT_EN
  // The popcount fits in 6 bits for WIDTH up to 32; the sum is widened so the
  // overflow check works even for very small CNT_W.
  localparam int SUM_W = CNT_W + 7;

  logic [5:0]       pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [SUM_W-1:0] cnt_max;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + {5'b0, diff[i]};
    end
  end

  // Clamp to the all-ones value instead of wrapping.
  always_comb begin
    cnt_max  = {{7{1'b0}}, {CNT_W{1'b1}}};
    cnt_sum  = {{7{1'b0}}, toggle_cnt} + {{(CNT_W + 1){1'b0}}, pop};
    cnt_next = toggle_cnt;
    if (cnt_sum > cnt_max) begin
      cnt_next = {CNT_W{1'b1}};
    end else begin
      cnt_next = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if (en) begin
      toggle_cnt <= cnt_next;
    end
  end
`else
  assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_reg_array.sv
// tb_jk_reg_array
// Directed checks of jk_reg_array with hand-computed expectations. A main
// instance (CNT_W=16, RST_VAL=8'hA5) covers the flip-flop modes and flags; a
// second instance with CNT_W=4 shares the inputs and covers counter
// saturation. Counter expectations collapse to 0 when JK_REG_TOGGLE_CNT_EN is
// undefined.
module tb_jk_reg_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  j = 8'h00;
  logic [7:0]  k = 8'h00;
  logic        clr_err = 1'b0;

  logic [7:0]  q, q_n;
  logic        changed, sr_err;
  logic [15:0] toggle_cnt;

  logic [7:0]  sat_q, sat_q_n;
  logic        sat_changed, sat_sr_err;
  logic [3:0]  sat_cnt;

  int testsRun = 0;
  int testsFailed = 0;

`ifdef JK_REG_TOGGLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  jk_reg_array #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k),
    .clr_err(clr_err), .q(q), .q_n(q_n), .changed(changed),
    .sr_err(sr_err), .toggle_cnt(toggle_cnt)
  );

  jk_reg_array #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k),
    .clr_err(clr_err), .q(sat_q), .q_n(sat_q_n), .changed(sat_changed),
    .sr_err(sat_sr_err), .toggle_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expCnt(input logic [31:0] v);
    return CNT_ON ? v : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one set of inputs, then advance one edge and settle.
  task automatic applyStimulus(input logic e, input logic [1:0] m,
                               input logic [7:0] jv, input logic [7:0] kv,
                               input logic c);
    en = e; mode = m; j = jv; k = kv; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkMain(input string tag, input logic [7:0] eq,
                           input logic ech, input logic eerr,
                           input logic [31:0] ecnt);
    checkOutput({tag, ".q"}, {24'b0, q}, {24'b0, eq});
    checkOutput({tag, ".q_n"}, {24'b0, q_n}, {24'b0, ~eq});
    checkOutput({tag, ".changed"}, {31'b0, changed}, {31'b0, ech});
    checkOutput({tag, ".sr_err"}, {31'b0, sr_err}, {31'b0, eerr});
    checkOutput({tag, ".cnt"}, {16'b0, toggle_cnt}, expCnt(ecnt));
  endtask

  initial begin
    // Scenario 1: reset, then hold with en=0
    #2 rst_n = 1'b0;
    #1 checkMain("reset", 8'hA5, 1'b0, 1'b0, 0);
    @(posedge clk);
    #3;
    en = 1'b0; mode = 2'b10; j = 8'hFF; k = 8'hFF;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b10, 8'hFF, 8'hFF, 1'b0);
      checkMain("hold", 8'hA5, 1'b0, 1'b0, 0);
    end

    // Scenario 2: load 0F with D, then JK j=33 k=55 -> 3A
    applyStimulus(1'b1, 2'b01, 8'h0F, 8'h00, 1'b0);
    checkMain("d_load", 8'h0F, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 2'b00, 8'h33, 8'h55, 1'b0);
    checkMain("jk", 8'h3A, 1'b1, 1'b0, 8);

    // Scenario 3: D then two T edges, then a D edge that changes nothing
    applyStimulus(1'b1, 2'b01, 8'hC3, 8'hFF, 1'b0);
    checkMain("d", 8'hC3, 1'b1, 1'b0, 14);
    applyStimulus(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    checkMain("t1", 8'h3C, 1'b1, 1'b0, 22);
    applyStimulus(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    checkMain("t2", 8'hC3, 1'b1, 1'b0, 30);
    applyStimulus(1'b1, 2'b01, 8'hC3, 8'h00, 1'b0);
    checkMain("d_same", 8'hC3, 1'b0, 1'b0, 30);

    // Scenario 4: SR with an illegal bit, sticky flag, clear priority
    applyStimulus(1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
    checkMain("d_zero", 8'h00, 1'b1, 1'b0, 34);
    applyStimulus(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0);
    checkMain("sr_dis", 8'h00, 1'b0, 1'b0, 34);
    applyStimulus(1'b1, 2'b11, 8'h81, 8'h01, 1'b0);
    checkMain("sr_bad", 8'h80, 1'b1, 1'b1, 35);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b11, 8'h00, 8'h00, 1'b0);
      checkMain("sr_sticky", 8'h80, 1'b0, 1'b1, 35);
    end
    applyStimulus(1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
    checkMain("sr_setwins", 8'h80, 1'b0, 1'b1, 35);
    applyStimulus(1'b0, 2'b11, 8'h00, 8'h00, 1'b1);
    checkMain("sr_clr", 8'h80, 1'b0, 1'b0, 35);
    applyStimulus(1'b1, 2'b11, 8'h02, 8'h80, 1'b0);
    checkMain("sr_legal", 8'h02, 1'b1, 1'b0, 37);

    // Scenario 6: asynchronous reset between edges during T operation
    applyStimulus(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    checkMain("t_pre", 8'hFD, 1'b1, 1'b0, 45);
    #1 rst_n = 1'b0;
    #1 checkMain("async_rst", 8'hA5, 1'b0, 1'b0, 0);
    checkOutput("async_rst.sat_cnt", {28'b0, sat_cnt}, 32'd0);
    en = 1'b0;
    #1 rst_n = 1'b1;

    // Scenario 5: saturation on the CNT_W=4 instance
    applyStimulus(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    checkMain("sat1", 8'h5A, 1'b1, 1'b0, 8);
    checkOutput("sat1.cnt4", {28'b0, sat_cnt}, expCnt(8));
    applyStimulus(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    checkOutput("sat2.cnt4", {28'b0, sat_cnt}, expCnt(15));
    checkOutput("sat2.q", {24'b0, sat_q}, 32'hA5);
    applyStimulus(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    checkOutput("sat3.cnt4", {28'b0, sat_cnt}, expCnt(15));
    checkMain("sat3", 8'h5A, 1'b1, 1'b0, 24);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
